// File: rtl/ad_nios_match_pkg.sv
// Shared definitions for the cascade match sink: register map, control/status
// bit positions and the arming state machine encoding.
package ad_nios_match_pkg;

  localparam logic [2:0] REG_PATTERN   = 3'd0;
  localparam logic [2:0] REG_MASK      = 3'd1;
  localparam logic [2:0] REG_CTRL      = 3'd2;
  localparam logic [2:0] REG_STATUS    = 3'd3;
  localparam logic [2:0] REG_CAPTURE   = 3'd4;
  localparam logic [2:0] REG_HIT_COUNT = 3'd5;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_ONE_SHOT = 2;

  localparam int STATUS_HIT = 0;
  localparam int STATUS_OVF = 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIGGERED = 2'd2
  } state_t;

endpackage

// File: rtl/ad_nios_match_seg_cmp.sv
// One compare segment: masked equality of a SEG_W-bit slice, registered so the
// result lines up with the first pipeline stage.
module ad_nios_match_seg_cmp #(
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEG_W-1:0] data,
  input  logic [SEG_W-1:0] pattern,
  input  logic [SEG_W-1:0] mask,
  output logic             ok
);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ok <= 1'b0;
    else       ok <= ~|((data ^ pattern) & mask);
  end

endmodule

// File: rtl/ad_nios_cascade_match_sink.sv
// Terminal end of the compare chain: two-stage match pipeline, arming FSM,
// hit capture/counting and the Avalon-MM register file with irq.
module ad_nios_cascade_match_sink
  import ad_nios_match_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SEG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic [2:0]        address,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              irq
);

  localparam int NSEG = DATA_W / SEG_W;

  logic [DATA_W-1:0] pattern_q, mask_q, capture_q, d1, d2, rd_mux;
  logic [2:0]        ctrl_q;
  logic              hit_q, ovf_q, v1, hit2;
  logic [CNT_W-1:0]  count_q;
  logic [NSEG-1:0]   seg_ok;
  state_t            state_q, state_d;

  logic wr_en, rd_en, hit_event, clr_hit, clr_ovf, clr_cnt;

  assign wr_en   = chipselect & ~write_n;
  assign rd_en   = chipselect & ~read_n;
  assign clr_hit = wr_en && (address == REG_STATUS) && writedata[STATUS_HIT];
  assign clr_ovf = wr_en && (address == REG_STATUS) && writedata[STATUS_OVF];
  assign clr_cnt = wr_en && (address == REG_HIT_COUNT);

  // Gated by enable too, so dropping enable kills a hit already sitting in S2.
  assign hit_event = hit2 && (state_q == ST_ARMED) && ctrl_q[CTRL_ENABLE];

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    ad_nios_match_seg_cmp #(.SEG_W(SEG_W)) u_seg (
      .clk     (clk),
      .reset   (reset),
      .data    (sample_data[g*SEG_W +: SEG_W]),
      .pattern (pattern_q[g*SEG_W +: SEG_W]),
      .mask    (mask_q[g*SEG_W +: SEG_W]),
      .ok      (seg_ok[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1   <= 1'b0;
      hit2 <= 1'b0;
      d1   <= '0;
      d2   <= '0;
    end else begin
      v1   <= sample_valid && (state_q == ST_ARMED);
      d1   <= sample_data;
      d2   <= d1;
      hit2 <= (state_q == ST_IDLE) ? 1'b0 : (v1 & (&seg_ok));
    end
  end

  // NOTE: next-state starts from a default so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (!ctrl_q[CTRL_ENABLE]) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = ST_ARMED;
        ST_ARMED:     if (hit_event && ctrl_q[CTRL_ONE_SHOT]) state_d = ST_TRIGGERED;
        ST_TRIGGERED: if (!hit_q) state_d = ST_ARMED;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q <= '0;
      mask_q    <= '0;
      ctrl_q    <= '0;
      hit_q     <= 1'b0;
      ovf_q     <= 1'b0;
      capture_q <= '0;
      count_q   <= '0;
      irq       <= 1'b0;
    end else begin
      if (wr_en && address == REG_PATTERN) pattern_q <= writedata;
      if (wr_en && address == REG_MASK)    mask_q    <= writedata;
      if (wr_en && address == REG_CTRL)    ctrl_q    <= writedata[2:0];

      // A new hit beats a simultaneous clear; the first capture is kept otherwise.
      if (hit_event && (!hit_q || clr_hit)) capture_q <= d2;
      if (hit_event)    hit_q <= 1'b1;
      else if (clr_hit) hit_q <= 1'b0;

      if (hit_event && hit_q && !clr_hit) ovf_q <= 1'b1;
      else if (clr_ovf)                   ovf_q <= 1'b0;

      if (clr_cnt)                      count_q <= hit_event ? CNT_W'(1) : '0;
      else if (hit_event && ~&count_q)  count_q <= count_q + CNT_W'(1);

      irq <= hit_q & ctrl_q[CTRL_IRQ_EN];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      REG_PATTERN:   rd_mux = pattern_q;
      REG_MASK:      rd_mux = mask_q;
      REG_CTRL:      rd_mux = DATA_W'(ctrl_q);
      REG_STATUS:    rd_mux = DATA_W'({ovf_q, hit_q});
      REG_CAPTURE:   rd_mux = capture_q;
      REG_HIT_COUNT: rd_mux = DATA_W'(count_q);
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      readdata <= '0;
    else if (rd_en) readdata <= rd_mux;
  end

endmodule

// File: tb/tb_ad_nios_cascade_match_sink.sv
// Scoreboard bench for the cascade match sink: a transaction-level model predicts
// readdata and irq; a negedge monitor pops the expectations and compares.
module tb_ad_nios_cascade_match_sink;

  localparam int DATA_W = 32;
  localparam int SEG_W  = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              chipselect = 1'b0;
  logic [2:0]        address = '0;
  logic              write_n = 1'b1;
  logic              read_n = 1'b1;
  logic [DATA_W-1:0] writedata = '0;
  logic [DATA_W-1:0] readdata;
  logic [DATA_W-1:0] sample_data = '0;
  logic              sample_valid = 1'b0;
  logic              irq;

  always #5 clk = ~clk;

  ad_nios_cascade_match_sink #(.DATA_W(DATA_W), .SEG_W(SEG_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .chipselect   (chipselect),
    .address      (address),
    .write_n      (write_n),
    .read_n       (read_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .irq          (irq)
  );

  typedef struct {
    logic [31:0] val;
    string       name;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    bit          match;
    int          e;
  } flight_t;

  exp_t    rd_q[$];
  bit      irq_q[$];
  flight_t flight[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: whole-register view, hits delayed two edges via a queue.
  int          m_edge = 0;
  int          m_state = 0;  // 0 idle, 1 armed, 2 triggered
  logic [31:0] m_pattern, m_mask, m_capture;
  logic [2:0]  m_ctrl;
  bit          m_hit, m_ovf;
  int          m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   ei;
    if (irq_q.size() > 0) begin
      ei = irq_q.pop_front();
      check("irq", {31'b0, irq}, {31'b0, ei});
    end
    if (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      check(e.name, readdata, e.val);
    end
  end

  task automatic model_reset();
    m_state = 0; m_pattern = '0; m_mask = '0; m_capture = '0;
    m_ctrl = '0; m_hit = 0; m_ovf = 0; m_count = 0;
    flight.delete();
  endtask

  // Predicts the effect of one clock edge given the inputs applied before it.
  task automatic model_edge(input bit w, input logic [2:0] a, input logic [31:0] wd,
                            input bit sv, input logic [31:0] sd,
                            output logic [31:0] rexp, output bit iexp);
    bit          hit_ev = 0;
    bit          clr_hit, clr_ovf;
    logic [31:0] land_d = '0;
    int          nstate;
    flight_t     f;

    case (a)
      3'd0:    rexp = m_pattern;
      3'd1:    rexp = m_mask;
      3'd2:    rexp = {29'b0, m_ctrl};
      3'd3:    rexp = {30'b0, m_ovf, m_hit};
      3'd4:    rexp = m_capture;
      3'd5:    rexp = 32'(m_count);
      default: rexp = '0;
    endcase
    iexp = m_hit & m_ctrl[1];

    if (flight.size() > 0 && flight[0].e == m_edge - 2) begin
      f = flight.pop_front();
      hit_ev = f.match && m_state == 1 && m_ctrl[0];
      land_d = f.d;
    end
    if (m_state == 0) flight.delete();
    if (sv && m_state == 1) begin
      f.d = sd;
      f.match = ((sd ^ m_pattern) & m_mask) == 32'h0;
      f.e = m_edge;
      flight.push_back(f);
    end

    nstate = m_state;
    if (!m_ctrl[0])                                 nstate = 0;
    else if (m_state == 0)                          nstate = 1;
    else if (m_state == 1 && hit_ev && m_ctrl[2])   nstate = 2;
    else if (m_state == 2 && !m_hit)                nstate = 1;

    clr_hit = w && a == 3'd3 && wd[0];
    clr_ovf = w && a == 3'd3 && wd[1];

    if (hit_ev && m_hit && !clr_hit) m_ovf = 1;
    else if (clr_ovf)                m_ovf = 0;
    if (hit_ev && (!m_hit || clr_hit)) m_capture = land_d;
    if (hit_ev)       m_hit = 1;
    else if (clr_hit) m_hit = 0;

    if (w && a == 3'd5)                  m_count = hit_ev ? 1 : 0;
    else if (hit_ev && m_count < 65535)  m_count++;

    if (w && a == 3'd0) m_pattern = wd;
    if (w && a == 3'd1) m_mask = wd;
    if (w && a == 3'd2) m_ctrl = wd[2:0];

    m_state = nstate;
    m_edge++;
  endtask

  // NOTE: stimulus is driven with blocking assignments, #1 after the edge, clear of the sampling edge.
  task automatic cycle(input bit w, input bit r, input logic [2:0] a, input logic [31:0] wd,
                       input bit sv, input logic [31:0] sd, input string nm);
    logic [31:0] rexp;
    bit          iexp;
    exp_t        x;
    chipselect = w | r; write_n = ~w; read_n = ~r; address = a; writedata = wd;
    sample_valid = sv; sample_data = sd;
    model_edge(w, a, wd, sv, sd, rexp, iexp);
    @(posedge clk); #1;
    irq_q.push_back(iexp);
    if (r) begin
      x.val = rexp; x.name = nm;
      rd_q.push_back(x);
    end
    chipselect = 0; write_n = 1; read_n = 1; sample_valid = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cycle(1, 0, a, d, 0, '0, "");
  endtask

  task automatic rd(input logic [2:0] a, input string nm);
    cycle(0, 1, a, '0, 0, '0, nm);
  endtask

  task automatic sample(input logic [31:0] d);
    cycle(0, 0, 3'd0, '0, 1, d, "");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 3'd0, '0, 0, '0, "");
  endtask

  task automatic do_reset();
    exp_t x;
    @(negedge clk); #1;
    reset = 1; chipselect = 0; write_n = 1; read_n = 1; sample_valid = 0;
    model_reset();
    @(posedge clk); #1;
    irq_q.push_back(1'b0);
    x.val = '0; x.name = "rst_readdata";
    rd_q.push_back(x);
    @(negedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] pat, sd, wd;
    int          op;

    model_reset();
    do_reset();
    rd(3'd3, "rst_status"); rd(3'd5, "rst_count"); rd(3'd2, "rst_ctrl");

    // Full-width match, status polled every cycle for hit/irq latency
    wr(3'd0, 32'h1234_5678); wr(3'd1, 32'hFFFF_FFFF); wr(3'd2, 32'h3);
    idle(2);
    sample(32'h1234_5678);
    for (int i = 0; i < 5; i++) rd(3'd3, "t1_status_poll");
    rd(3'd4, "t1_capture"); rd(3'd5, "t1_count");

    // Low-byte mask: only the first of two samples matches
    wr(3'd1, 32'h0000_00FF); wr(3'd0, 32'h0000_0078); wr(3'd3, 32'h3); wr(3'd5, 0);
    sample(32'hAAAA_AA78); sample(32'hAAAA_AA79);
    idle(3);
    rd(3'd3, "t2_status"); rd(3'd4, "t2_capture"); rd(3'd5, "t2_count");

    // One-shot: back-to-back matches count once, then re-arm via W1C
    wr(3'd2, 32'h7); wr(3'd3, 32'h3); wr(3'd5, 0);
    idle(2);
    sample(32'h1111_1178); sample(32'h2222_2278); sample(32'h3333_3378);
    idle(3);
    rd(3'd5, "t3_count_trig"); rd(3'd4, "t3_capture");
    wr(3'd3, 32'h1);
    idle(2);
    sample(32'h4444_4478);
    idle(3);
    rd(3'd5, "t3_count_rearm"); rd(3'd4, "t3_capture_rearm");

    // Continuous mode: overflow, then W1C colliding with a third hit
    wr(3'd2, 32'h3); wr(3'd3, 32'h3); wr(3'd5, 0);
    idle(2);
    sample(32'hA1A1_A178); idle(2); sample(32'hA2A2_A278);
    idle(3);
    rd(3'd3, "t4_status_ovf"); rd(3'd4, "t4_capture_first"); rd(3'd5, "t4_count");
    sample(32'hA3A3_A378); idle(1); wr(3'd3, 32'h1);
    idle(1);
    rd(3'd3, "t4_status_w1c_hit"); rd(3'd4, "t4_capture_third");

    // Count clear colliding with a hit, then saturation
    sample(32'hB0B0_B078); idle(1); wr(3'd5, 0);
    rd(3'd5, "t5_count_clear_hit");
    for (int i = 0; i < 65540; i++) sample($urandom & 32'hFFFF_FF00 | 32'h78);
    idle(3);
    rd(3'd5, "t5_count_sat");
    sample(32'h78); sample(32'h178);
    idle(3);
    rd(3'd5, "t5_count_sat_hold");
    rd(3'd6, "t5_reg6"); wr(3'd7, 32'hFFFF_FFFF); rd(3'd7, "t5_reg7");

    // Reset with a match in flight; disable with a match in S2
    wr(3'd3, 32'h3);
    sample(32'h78);
    do_reset();
    idle(3);
    rd(3'd3, "t6_status_after_rst"); rd(3'd5, "t6_count_after_rst"); rd(3'd4, "t6_capture_after_rst");
    wr(3'd0, 32'h5555_0000); wr(3'd1, 32'hFFFF_0000); wr(3'd2, 32'h3);
    idle(2);
    sample(32'h5555_1234); wr(3'd2, 32'h0);
    idle(3);
    rd(3'd3, "t6_status_disabled"); rd(3'd5, "t6_count_disabled");

    // Randomized traffic against the model
    wr(3'd0, $urandom); wr(3'd1, $urandom); wr(3'd2, 32'h3);
    for (int i = 0; i < 3000; i++) begin
      op  = $urandom_range(0, 99);
      pat = (m_pattern & m_mask) | ($urandom & ~m_mask);
      sd  = ($urandom_range(0, 1) == 1) ? pat : $urandom;
      wd  = $urandom;
      if (op < 4)       cycle(1, 0, 3'd2, {29'b0, wd[2:1], (wd[5:3] != 0)}, 1, sd, "");
      else if (op < 14) cycle(1, 0, 3'd3, wd, 1, sd, "");
      else if (op < 17) cycle(1, 0, 3'd5, wd, 1, sd, "");
      else if (op < 19) cycle(1, 0, 3'd0, wd, 1, sd, "");
      else if (op < 21) cycle(1, 0, 3'd1, wd | 32'hF0F0_0000, 1, sd, "");
      else if (op < 45) cycle(0, 1, 3'($urandom_range(0, 7)), '0, 1, sd, "rand_read");
      else              cycle(0, 0, 3'd0, '0, ($urandom_range(0, 3) != 0), sd, "");
    end
    for (int a = 0; a < 8; a++) rd(3'(a), "rand_final_read");
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
